mips_multicycle: RTL

Multi-cycle MIPS-I subset core, the successor to the single-cycle CPU top. It replaces separate instruction and data ports with one shared memory port using a req/ready handshake, so it tolerates wait states. A state machine sequences fetch, decode, execute, memory and writeback across cycles, sharing one ALU. It adds `beq`, `j` and an illegal-opcode trap. It sits between the SoC memory/interconnect and nothing else; it is the whole core.

---
 rtl/mips_pkg.sv | 97 +++++++++
 rtl/mips_mc_ctrl.sv | 111 +++++++++++
 rtl/mips_multicycle.sv | 113 +++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the multi-cycle MIPS-I subset core.
// Holds opcode/funct encodings, the FSM state and ALU operation enums,
// the control-bundle struct driven by the controller into the datapath,
// and small decode/ALU helper functions.
package mips_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_JUMP,
    S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    PC_INC,
    PC_BRANCH,
    PC_JUMP
  } pc_src_t;

  // Per-cycle datapath controls produced by the FSM
  typedef struct packed {
    logic    irwrite;
    logic    pcwrite;
    logic    pccond;
    pc_src_t pc_src;
    logic    regwrite;
    logic    regdst;
    logic    memtoreg;
    logic    mdrwrite;
    logic    abwrite;
    logic    aluoutwrite;
    logic    alusrc_imm;
    alu_op_t alu_op;
  } ctrl_t;

  function automatic logic funct_ok(input logic [5:0] fn);
    return fn inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT};
  endfunction

  function automatic alu_op_t funct_alu(input logic [5:0] fn);
    alu_op_t op;
    case (fn)
      FN_SUB:  op = ALU_SUB;
      FN_AND:  op = ALU_AND;
      FN_OR:   op = ALU_OR;
      FN_SLT:  op = ALU_SLT;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  function automatic logic [XLEN-1:0] alu_fn(input alu_op_t op,
                                             input logic [XLEN-1:0] a,
                                             input logic [XLEN-1:0] b);
    logic [XLEN-1:0] y;
    case (op)
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = XLEN'($signed(a) < $signed(b));
      default: y = a + b;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/mips_mc_ctrl.sv
// Controller for the multi-cycle core: FSM sequencing plus instruction decode.
// Ports: clk/rst (async active-high), op/funct from IR, mem_ready handshake;
// ctrl_c combinational datapath controls for the current state, fetch_next_c
// flags that the next state is FETCH (address mux select for the registered
// address), and registered mem_req, mem_we and sticky trap.
module mips_mc_ctrl
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output ctrl_t      ctrl_c,
  output logic       fetch_next_c,
  output logic       mem_req,
  output logic       mem_we,
  output logic       trap
);

  state_t state, next_state;

  // State register; bus strobes are registered off the next state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      trap    <= 1'b0;
    end else begin
      state   <= next_state;
      mem_req <= next_state inside {S_FETCH, S_MEMRD, S_MEMWR};
      mem_we  <= (next_state == S_MEMWR);
      trap    <= (next_state == S_TRAP);
    end
  end

  // Next-state and control decode
  always_comb begin
    next_state    = state;
    ctrl_c        = '0;
    ctrl_c.pc_src = PC_INC;
    ctrl_c.alu_op = ALU_ADD;
    case (state)
      S_IDLE: next_state = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          ctrl_c.irwrite = 1'b1;
          ctrl_c.pcwrite = 1'b1;
          next_state     = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl_c.abwrite = 1'b1;
        case (op)
          OP_LW, OP_SW: next_state = S_MEMADR;
          OP_RTYPE:     next_state = funct_ok(funct) ? S_EXEC : S_TRAP;
          OP_ADDI:      next_state = S_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
          OP_J:         next_state = S_JUMP;
          default:      next_state = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ctrl_c.aluoutwrite = 1'b1;
        ctrl_c.alusrc_imm  = 1'b1;
        next_state         = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        if (mem_ready) begin
          ctrl_c.mdrwrite = 1'b1;
          next_state      = S_MEMWB;
        end
      end
      S_MEMWB: begin
        ctrl_c.regwrite = 1'b1;
        ctrl_c.memtoreg = 1'b1;
        next_state      = S_FETCH;
      end
      S_MEMWR: begin
        if (mem_ready) next_state = S_FETCH;
      end
      S_EXEC: begin
        ctrl_c.aluoutwrite = 1'b1;
        if (op == OP_ADDI) ctrl_c.alusrc_imm = 1'b1;
        else               ctrl_c.alu_op     = funct_alu(funct);
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        ctrl_c.regwrite = 1'b1;
        ctrl_c.regdst   = (op == OP_RTYPE);
        next_state      = S_FETCH;
      end
      S_BRANCH: begin
        ctrl_c.pccond = 1'b1;
        ctrl_c.pc_src = PC_BRANCH;
        next_state    = S_FETCH;
      end
      S_JUMP: begin
        ctrl_c.pcwrite = 1'b1;
        ctrl_c.pc_src  = PC_JUMP;
        next_state     = S_FETCH;
      end
      S_TRAP:  next_state = S_TRAP;
      default: next_state = S_IDLE;
    endcase
  end

  assign fetch_next_c = (next_state == S_FETCH);

endmodule

// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS-I subset core with a single shared req/ready memory port.
// Ports: sys_clk, sys_rst (async active-high); mem_req/mem_we/mem_addr/
// mem_wdata out, mem_rdata/mem_ready in; trap (sticky illegal instruction);
// pc_o current PC. Datapath (PC, IR, MDR, A, B, ALUOut, register file, ALU)
// lives here; sequencing comes from mips_mc_ctrl.
module mips_multicycle
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned NREGS    = 32
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic        trap,
  output logic [31:0] pc_o
);

  localparam int unsigned RW = $clog2(NREGS);

  ctrl_t       ctrl_c;
  logic        fetch_next_c;

  logic [31:0] pc_q, ir_q, mdr_q, a_q, b_q, aluout_q;
  logic [31:0] rf [NREGS];

  logic [RW-1:0] rs_idx, rt_idx, rd_idx, wb_idx;
  logic [31:0]   imm_sext, alu_b, alu_y;
  logic [31:0]   pc_target, pc_next, a_next, b_next, aluout_next, addr_next, wb_data;
  logic          pc_take;

  mips_mc_ctrl u_ctrl (
    .clk          (sys_clk),
    .rst          (sys_rst),
    .op           (ir_q[31:26]),
    .funct        (ir_q[5:0]),
    .mem_ready    (mem_ready),
    .ctrl_c       (ctrl_c),
    .fetch_next_c (fetch_next_c),
    .mem_req      (mem_req),
    .mem_we       (mem_we),
    .trap         (trap)
  );

  // Register indices use only the low log2(NREGS) bits of each field
  assign rs_idx   = ir_q[21 +: RW];
  assign rt_idx   = ir_q[16 +: RW];
  assign rd_idx   = ir_q[11 +: RW];
  assign imm_sext = {{16{ir_q[15]}}, ir_q[15:0]};

  assign alu_b = ctrl_c.alusrc_imm ? imm_sext : b_q;
  assign alu_y = alu_fn(ctrl_c.alu_op, a_q, alu_b);

  // PC already holds PC+4 once the instruction has been fetched
  always_comb begin
    case (ctrl_c.pc_src)
      PC_BRANCH: pc_target = pc_q + {imm_sext[29:0], 2'b00};
      PC_JUMP:   pc_target = {pc_q[31:28], ir_q[25:0], 2'b00};
      default:   pc_target = pc_q + 32'd4;
    endcase
  end

  assign pc_take     = ctrl_c.pcwrite | (ctrl_c.pccond & (a_q == b_q));
  assign pc_next     = pc_take ? pc_target : pc_q;
  assign a_next      = ctrl_c.abwrite ? rf[rs_idx] : a_q;
  assign b_next      = ctrl_c.abwrite ? rf[rt_idx] : b_q;
  assign aluout_next = ctrl_c.aluoutwrite ? alu_y : aluout_q;
  // Address is registered one cycle ahead so it is stable for the whole access
  assign addr_next   = fetch_next_c ? pc_next : aluout_next;

  assign wb_idx  = ctrl_c.regdst ? rd_idx : rt_idx;
  assign wb_data = ctrl_c.memtoreg ? mdr_q : aluout_q;

  // Datapath registers and memory-port outputs
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      mdr_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      aluout_q  <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      pc_q      <= pc_next;
      a_q       <= a_next;
      b_q       <= b_next;
      aluout_q  <= aluout_next;
      mem_addr  <= {addr_next[31:2], 2'b00};
      mem_wdata <= b_next;
      if (ctrl_c.irwrite)  ir_q  <= mem_rdata;
      if (ctrl_c.mdrwrite) mdr_q <= mem_rdata;
    end
  end

  // Register file; writes to register 0 are dropped so it always reads 0
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < int'(NREGS); i++) rf[i] <= '0;
    end else if (ctrl_c.regwrite && (wb_idx != '0)) begin
      rf[wb_idx] <= wb_data;
    end
  end

  assign pc_o = pc_q;

endmodule
